// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, funct codes, ALU and PC-select encodings, control bundle.
// Consumers may be built with REGFILE_BYPASS_EN to enable register-file write-through.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_SLT = 4'd4,
      ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_LUI = 4'd7, ALU_PASSA = 4'd8
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_SEQ = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_JR = 2'd3
   } pc_src_e;

   typedef enum logic [1:0] {IMM_SEXT = 2'd0, IMM_ZEXT = 2'd1, IMM_LUI = 2'd2} imm_sel_e;
   typedef enum logic [1:0] {DEST_NONE = 2'd0, DEST_RT = 2'd1, DEST_RD = 2'd2, DEST_RA = 2'd3} dest_sel_e;

   typedef struct packed {
      logic      valid;
      logic      reg_write;
      logic      mem_read;
      logic      mem_write;
      logic      mem_to_reg;
      logic      alu_src;
      alu_op_e   alu_op;
      imm_sel_e  imm_sel;
      dest_sel_e dest_sel;
      logic      uses_rs;
      logic      uses_rt;
      logic      is_beq;
      logic      is_bne;
      logic      is_j;
      logic      is_jal;
      logic      is_jr;
   } ctrl_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc4;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dest;
      logic [4:0]  shamt;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        alu_src;
      logic [3:0]  alu_op;
   } id_ex_t;

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file, two combinational read ports, one write port, $0 hardwired to zero.
// REGFILE_BYPASS_EN makes a same-cycle write visible on the read ports.
module mips_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ra_a,
   input  logic [4:0]  ra_b,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd_a,
   output logic [31:0] rd_b
);

   logic [31:0] regs_q [32];
   logic [31:0] regs_d [32];

   // next-state of the array: one register updated per write
   always_comb begin
      regs_d = regs_q;
      if (we && (wa != 5'd0)) begin
         regs_d[wa] = wd;
      end else begin
         regs_d = regs_q;
      end
   end

   // storage, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= 32'd0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // read port A (wa != 0 is implied by ra_a != 0)
   always_comb begin
      if (ra_a == 5'd0) begin
         rd_a = 32'd0;
`ifdef REGFILE_BYPASS_EN
      end else if (we && (ra_a == wa)) begin
         rd_a = wd;
`endif
      end else begin
         rd_a = regs_q[ra_a];
      end
   end

   // read port B
   always_comb begin
      if (ra_b == 5'd0) begin
         rd_b = 32'd0;
`ifdef REGFILE_BYPASS_EN
      end else if (we && (ra_b == wa)) begin
         rd_b = wd;
`endif
      end else begin
         rd_b = regs_q[ra_b];
      end
   end

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: control decode, immediates, branch/jump resolution, hazard stall, ID/EX register.
// Without REGFILE_BYPASS_EN a same-cycle WB write to a used source costs one stall cycle.
module id_stage
   import mips_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] if_id_instr,
   input  logic [31:0] if_id_pc4,
   input  logic        if_id_valid,
   input  logic        wb_we,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_data,
   input  logic        ex_reg_write,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_dest,
   input  logic        mem_mem_read,
   input  logic [4:0]  mem_dest,
   output logic        stall,
   output logic        flush_if,
   output logic [1:0]  pc_src,
   output logic [31:0] pc_target,
   output logic        id_ex_valid,
   output logic [31:0] id_ex_pc4,
   output logic [31:0] id_ex_rs_data,
   output logic [31:0] id_ex_rt_data,
   output logic [31:0] id_ex_imm,
   output logic [4:0]  id_ex_rs,
   output logic [4:0]  id_ex_rt,
   output logic [4:0]  id_ex_dest,
   output logic [4:0]  id_ex_shamt,
   output logic        id_ex_reg_write,
   output logic        id_ex_mem_read,
   output logic        id_ex_mem_write,
   output logic        id_ex_mem_to_reg,
   output logic        id_ex_alu_src,
   output logic [3:0]  id_ex_alu_op
);

   logic [5:0]  opcode_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s, dest_s;
   logic [15:0] imm16_s;
   logic [31:0] imm_s, rs_data_s, rt_data_s, br_target_s, j_target_s;
   ctrl_t       ctrl_s;
   logic        load_use_s, br_hazard_s, wb_hazard_s, stall_s;
   pc_src_e     pc_src_s;
   logic [31:0] pc_target_s;
   id_ex_t      id_ex_d, id_ex_q;

   assign opcode_s = if_id_instr[31:26];
   assign rs_s     = if_id_instr[25:21];
   assign rt_s     = if_id_instr[20:16];
   assign rd_s     = if_id_instr[15:11];
   assign funct_s  = if_id_instr[5:0];
   assign imm16_s  = if_id_instr[15:0];

   function automatic logic src_hit(input logic [4:0] dst, input ctrl_t c,
                                    input logic [4:0] rs, input logic [4:0] rt);
      return (dst != 5'd0) && ((c.uses_rs && (dst == rs)) || (c.uses_rt && (dst == rt)));
   endfunction

   mips_regfile u_regfile (
      .clk(clk), .rst(rst), .ra_a(rs_s), .ra_b(rt_s),
      .we(wb_we), .wa(wb_rd), .wd(wb_data), .rd_a(rs_data_s), .rd_b(rt_data_s)
   );

   // control decode; anything unrecognised collapses to a bubble
   always_comb begin
      ctrl_s = '0;
      case (opcode_s)
         OP_RTYPE: begin
            ctrl_s.valid = 1'b1; ctrl_s.reg_write = 1'b1; ctrl_s.dest_sel = DEST_RD;
            ctrl_s.uses_rs = 1'b1; ctrl_s.uses_rt = 1'b1;
            case (funct_s)
               FN_ADD:  ctrl_s.alu_op = ALU_ADD;
               FN_SUB:  ctrl_s.alu_op = ALU_SUB;
               FN_AND:  ctrl_s.alu_op = ALU_AND;
               FN_OR:   ctrl_s.alu_op = ALU_OR;
               FN_SLT:  ctrl_s.alu_op = ALU_SLT;
               FN_SLL:  begin ctrl_s.alu_op = ALU_SLL; ctrl_s.uses_rs = 1'b0; end
               FN_SRL:  begin ctrl_s.alu_op = ALU_SRL; ctrl_s.uses_rs = 1'b0; end
               FN_JR:   begin
                  ctrl_s.reg_write = 1'b0; ctrl_s.dest_sel = DEST_NONE;
                  ctrl_s.uses_rt = 1'b0; ctrl_s.is_jr = 1'b1;
               end
               default: ctrl_s = '0;
            endcase
         end
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI, OP_LW: begin
            ctrl_s.valid = 1'b1; ctrl_s.reg_write = 1'b1; ctrl_s.alu_src = 1'b1;
            ctrl_s.uses_rs = 1'b1; ctrl_s.dest_sel = DEST_RT;
            case (opcode_s)
               OP_ADDI: ctrl_s.alu_op = ALU_ADD;
               OP_SLTI: ctrl_s.alu_op = ALU_SLT;
               OP_ANDI: begin ctrl_s.alu_op = ALU_AND; ctrl_s.imm_sel = IMM_ZEXT; end
               OP_ORI:  begin ctrl_s.alu_op = ALU_OR;  ctrl_s.imm_sel = IMM_ZEXT; end
               OP_LUI:  begin
                  ctrl_s.alu_op = ALU_LUI; ctrl_s.imm_sel = IMM_LUI; ctrl_s.uses_rs = 1'b0;
               end
               OP_LW:   begin
                  ctrl_s.alu_op = ALU_ADD; ctrl_s.mem_read = 1'b1; ctrl_s.mem_to_reg = 1'b1;
               end
               default: ctrl_s = '0;
            endcase
         end
         OP_SW: begin
            ctrl_s.valid = 1'b1; ctrl_s.alu_src = 1'b1; ctrl_s.mem_write = 1'b1;
            ctrl_s.uses_rs = 1'b1; ctrl_s.uses_rt = 1'b1; ctrl_s.alu_op = ALU_ADD;
         end
         OP_BEQ, OP_BNE: begin
            ctrl_s.valid = 1'b1; ctrl_s.uses_rs = 1'b1; ctrl_s.uses_rt = 1'b1;
            ctrl_s.alu_op = ALU_SUB;
            ctrl_s.is_beq = (opcode_s == OP_BEQ);
            ctrl_s.is_bne = (opcode_s == OP_BNE);
         end
         OP_J:    begin ctrl_s.valid = 1'b1; ctrl_s.is_j = 1'b1; end
         OP_JAL:  begin
            ctrl_s.valid = 1'b1; ctrl_s.is_jal = 1'b1; ctrl_s.reg_write = 1'b1;
            ctrl_s.alu_op = ALU_PASSA; ctrl_s.dest_sel = DEST_RA;
         end
         default: ctrl_s = '0;
      endcase
      if (!if_id_valid) begin
         ctrl_s = '0;
      end else begin
         ctrl_s = ctrl_s;
      end
   end

   // immediate extension and destination select
   always_comb begin
      case (ctrl_s.imm_sel)
         IMM_ZEXT: imm_s = {16'd0, imm16_s};
         IMM_LUI:  imm_s = {imm16_s, 16'd0};
         default:  imm_s = {{16{imm16_s[15]}}, imm16_s};
      endcase
      case (ctrl_s.dest_sel)
         DEST_RT: dest_s = rt_s;
         DEST_RD: dest_s = rd_s;
         DEST_RA: dest_s = 5'd31;
         default: dest_s = 5'd0;
      endcase
   end

   assign load_use_s  = ex_mem_read && src_hit(ex_dest, ctrl_s, rs_s, rt_s);
   assign br_hazard_s = (ctrl_s.is_beq || ctrl_s.is_bne || ctrl_s.is_jr) &&
                        ((ex_reg_write && src_hit(ex_dest, ctrl_s, rs_s, rt_s)) ||
                         (mem_mem_read && src_hit(mem_dest, ctrl_s, rs_s, rt_s)));
`ifdef REGFILE_BYPASS_EN
   assign wb_hazard_s = 1'b0;
`else
   assign wb_hazard_s = wb_we && src_hit(wb_rd, ctrl_s, rs_s, rt_s);
`endif
   assign stall_s = ctrl_s.valid && (load_use_s || br_hazard_s || wb_hazard_s);

   assign br_target_s = if_id_pc4 + {{14{imm16_s[15]}}, imm16_s, 2'b00};
   assign j_target_s  = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

   // redirect selection, suppressed while stalled
   always_comb begin
      pc_src_s    = PC_SEQ;
      pc_target_s = if_id_pc4;
      if (!stall_s) begin
         if ((ctrl_s.is_beq && (rs_data_s == rt_data_s)) ||
             (ctrl_s.is_bne && (rs_data_s != rt_data_s))) begin
            pc_src_s = PC_BRANCH; pc_target_s = br_target_s;
         end else if (ctrl_s.is_j || ctrl_s.is_jal) begin
            pc_src_s = PC_JUMP; pc_target_s = j_target_s;
         end else if (ctrl_s.is_jr) begin
            pc_src_s = PC_JR; pc_target_s = rs_data_s;
         end else begin
            pc_src_s = PC_SEQ;
         end
      end else begin
         pc_src_s = PC_SEQ;
      end
   end

   assign stall     = stall_s;
   assign pc_src    = pc_src_s;
   assign pc_target = pc_target_s;
   assign flush_if  = (pc_src_s != PC_SEQ);

   // ID/EX next value; a stall or an undecodable slot issues a bubble
   always_comb begin
      id_ex_d = '0;
      if (ctrl_s.valid && !stall_s) begin
         id_ex_d.valid      = 1'b1;
         id_ex_d.pc4        = if_id_pc4;
         id_ex_d.rs_data    = ctrl_s.is_jal ? if_id_pc4 : rs_data_s;
         id_ex_d.rt_data    = rt_data_s;
         id_ex_d.imm        = imm_s;
         id_ex_d.rs         = rs_s;
         id_ex_d.rt         = rt_s;
         id_ex_d.dest       = dest_s;
         id_ex_d.shamt      = if_id_instr[10:6];
         id_ex_d.reg_write  = ctrl_s.reg_write;
         id_ex_d.mem_read   = ctrl_s.mem_read;
         id_ex_d.mem_write  = ctrl_s.mem_write;
         id_ex_d.mem_to_reg = ctrl_s.mem_to_reg;
         id_ex_d.alu_src    = ctrl_s.alu_src;
         id_ex_d.alu_op     = ctrl_s.alu_op;
      end else begin
         id_ex_d = '0;
      end
   end

   // ID/EX pipeline register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign id_ex_valid      = id_ex_q.valid;
   assign id_ex_pc4        = id_ex_q.pc4;
   assign id_ex_rs_data    = id_ex_q.rs_data;
   assign id_ex_rt_data    = id_ex_q.rt_data;
   assign id_ex_imm        = id_ex_q.imm;
   assign id_ex_rs         = id_ex_q.rs;
   assign id_ex_rt         = id_ex_q.rt;
   assign id_ex_dest       = id_ex_q.dest;
   assign id_ex_shamt      = id_ex_q.shamt;
   assign id_ex_reg_write  = id_ex_q.reg_write;
   assign id_ex_mem_read   = id_ex_q.mem_read;
   assign id_ex_mem_write  = id_ex_q.mem_write;
   assign id_ex_mem_to_reg = id_ex_q.mem_to_reg;
   assign id_ex_alu_src    = id_ex_q.alu_src;
   assign id_ex_alu_op     = id_ex_q.alu_op;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed instructions push expected ID/EX records,
// a negedge monitor pops and compares whenever id_ex_valid is high.
module tb_id_stage;
   import mips_pkg::*;

   logic        clk, rst;
   logic [31:0] if_id_instr, if_id_pc4, wb_data;
   logic        if_id_valid, wb_we, ex_reg_write, ex_mem_read, mem_mem_read;
   logic [4:0]  wb_rd, ex_dest, mem_dest;
   logic        stall, flush_if, id_ex_valid;
   logic [1:0]  pc_src;
   logic [31:0] pc_target, id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm;
   logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest, id_ex_shamt;
   logic        id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src;
   logic [3:0]  id_ex_alu_op;

   id_stage dut (
      .clk(clk), .rst(rst), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
      .if_id_valid(if_id_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
      .mem_mem_read(mem_mem_read), .mem_dest(mem_dest), .stall(stall), .flush_if(flush_if),
      .pc_src(pc_src), .pc_target(pc_target), .id_ex_valid(id_ex_valid), .id_ex_pc4(id_ex_pc4),
      .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data), .id_ex_imm(id_ex_imm),
      .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_dest(id_ex_dest), .id_ex_shamt(id_ex_shamt),
      .id_ex_reg_write(id_ex_reg_write), .id_ex_mem_read(id_ex_mem_read),
      .id_ex_mem_write(id_ex_mem_write), .id_ex_mem_to_reg(id_ex_mem_to_reg),
      .id_ex_alu_src(id_ex_alu_src), .id_ex_alu_op(id_ex_alu_op)
   );

   typedef struct packed {
      logic [31:0] pc4, rs_data, rt_data, imm;
      logic [4:0]  rs, rt, dest, shamt;
      logic        rw, mr, mw, m2r, asrc;
      logic [3:0]  alu_op;
   } rec_t;

   rec_t  exp_q[$];
   string name_q[$];
   int    n_total = 0;
   int    n_pass  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h", name, act, req);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc4);
      if_id_instr = instr;
      if_id_pc4   = pc4;
      if_id_valid = 1'b1;
   endtask

   task automatic expect_issue(input string name, input logic [31:0] pc4, rsd, rtd, imm,
                               input logic [4:0] rs, rt, dest, shamt,
                               input logic rw, mr, mw, m2r, asrc, input logic [3:0] op);
      rec_t r;
      r = '{pc4, rsd, rtd, imm, rs, rt, dest, shamt, rw, mr, mw, m2r, asrc, op};
      exp_q.push_back(r);
      name_q.push_back(name);
   endtask

   task automatic wb_write(input logic [4:0] rd, input logic [31:0] data);
      if_id_valid = 1'b0;
      wb_we = 1'b1; wb_rd = rd; wb_data = data;
      tick();
      wb_we = 1'b0;
   endtask

   // monitor: every valid ID/EX output must match the oldest outstanding expectation
   initial begin
      rec_t act, req;
      string nm;
      forever begin
         @(negedge clk);
         if (id_ex_valid) begin
            act = '{id_ex_pc4, id_ex_rs_data, id_ex_rt_data, id_ex_imm, id_ex_rs, id_ex_rt,
                    id_ex_dest, id_ex_shamt, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write,
                    id_ex_mem_to_reg, id_ex_alu_src, id_ex_alu_op};
            if (exp_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_issue actual=%0h required=no_issue", act);
            end else begin
               req = exp_q.pop_front();
               nm  = name_q.pop_front();
               chk(nm, 256'(act), 256'(req));
            end
         end
      end
   end

   initial begin
      rst = 1'b1; wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
      ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dest = 5'd0;
      mem_mem_read = 1'b0; mem_dest = 5'd0;
      drive(32'h2001FFFB, 32'h0000_0004);
      repeat (2) tick();
      chk("reset_valid", 256'(id_ex_valid), 256'(1'b0));
      chk("reset_dest", 256'(id_ex_dest), 256'(5'd0));
      chk("reset_imm", 256'(id_ex_imm), 256'(32'd0));
      chk("reset_rw", 256'(id_ex_reg_write), 256'(1'b0));
      rst = 1'b0;
      if_id_valid = 1'b0;

      wb_write(5'd5, 32'd7);
      wb_write(5'd6, 32'd7);
      wb_write(5'd0, 32'h1234);
      wb_write(5'd4, 32'h10);
      wb_write(5'd2, 32'h22);

      // addi $1,$0,-5
      drive(32'h2001FFFB, 32'h4);
      expect_issue("addi", 32'h4, 32'd0, 32'd0, 32'hFFFFFFFB, 5'd0, 5'd1, 5'd1, 5'd31,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD);
      #2 chk("addi_stall", 256'(stall), 256'(1'b0));
      chk("addi_pcsrc", 256'(pc_src), 256'(2'd0));
      tick();

      // load-use on add $3,$2,$4
      drive(32'h00441820, 32'h8);
      ex_mem_read = 1'b1; ex_dest = 5'd2;
      #2 chk("lu_stall", 256'(stall), 256'(1'b1));
      chk("lu_flush", 256'(flush_if), 256'(1'b0));
      tick();
      chk("lu_bubble", 256'(id_ex_valid), 256'(1'b0));
      ex_mem_read = 1'b0; ex_dest = 5'd0;
      expect_issue("lu_add", 32'h8, 32'h22, 32'h10, 32'h1820, 5'd2, 5'd4, 5'd3, 5'd0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
      #2 chk("lu_release", 256'(stall), 256'(1'b0));
      tick();

      // beq $5,$6,+3 taken
      drive(32'h10A60003, 32'h100);
      expect_issue("beq_taken", 32'h100, 32'd7, 32'd7, 32'd3, 5'd5, 5'd6, 5'd0, 5'd0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
      #2 chk("beq_pcsrc", 256'(pc_src), 256'(2'd1));
      chk("beq_target", 256'(pc_target), 256'(32'h10C));
      chk("beq_flush", 256'(flush_if), 256'(1'b1));
      tick();
      wb_write(5'd6, 32'd8);
      drive(32'h10A60003, 32'h100);
      expect_issue("beq_not", 32'h100, 32'd7, 32'd8, 32'd3, 5'd5, 5'd6, 5'd0, 5'd0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
      #2 chk("beqn_pcsrc", 256'(pc_src), 256'(2'd0));
      chk("beqn_flush", 256'(flush_if), 256'(1'b0));
      tick();

      // bne $5,$0 with EX writing $5
      drive(32'h14A00004, 32'h200);
      ex_reg_write = 1'b1; ex_dest = 5'd5;
      #2 chk("bne_stall", 256'(stall), 256'(1'b1));
      chk("bne_nored", 256'(pc_src), 256'(2'd0));
      chk("bne_noflush", 256'(flush_if), 256'(1'b0));
      tick();
      ex_reg_write = 1'b0; ex_dest = 5'd0;
      expect_issue("bne", 32'h200, 32'd7, 32'd0, 32'd4, 5'd5, 5'd0, 5'd0, 5'd0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SUB);
      #2 chk("bne_pcsrc", 256'(pc_src), 256'(2'd1));
      chk("bne_target", 256'(pc_target), 256'(32'h210));
      chk("bne_flush", 256'(flush_if), 256'(1'b1));
      tick();

      // jr $5 with load of $5 in MEM
      drive(32'h00A00008, 32'h300);
      mem_mem_read = 1'b1; mem_dest = 5'd5;
      #2 chk("jr_stall", 256'(stall), 256'(1'b1));
      tick();
      mem_mem_read = 1'b0; mem_dest = 5'd0;
      expect_issue("jr", 32'h300, 32'd7, 32'd0, 32'd8, 5'd5, 5'd0, 5'd0, 5'd0,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
      #2 chk("jr_pcsrc", 256'(pc_src), 256'(2'd3));
      chk("jr_target", 256'(pc_target), 256'(32'd7));
      tick();

      // add $8,$7,$0 while WB writes $7
      drive(32'h00E04020, 32'h304);
      wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEAD;
`ifdef REGFILE_BYPASS_EN
      expect_issue("wb_same", 32'h304, 32'hDEAD, 32'd0, 32'h4020, 5'd7, 5'd0, 5'd8, 5'd0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
      #2 chk("wb_nostall", 256'(stall), 256'(1'b0));
      tick();
      wb_we = 1'b0;
`else
      #2 chk("wb_stall", 256'(stall), 256'(1'b1));
      tick();
      wb_we = 1'b0;
      expect_issue("wb_reread", 32'h304, 32'hDEAD, 32'd0, 32'h4020, 5'd7, 5'd0, 5'd8, 5'd0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
      #2 chk("wb_release", 256'(stall), 256'(1'b0));
      tick();
`endif

      // $0 still reads zero after the 0x1234 write
      drive(32'h00004820, 32'h400);
      expect_issue("r0_read", 32'h400, 32'd0, 32'd0, 32'h4820, 5'd0, 5'd0, 5'd9, 5'd0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD);
      tick();

      // jal 0x40 at pc4=0x20
      drive(32'h0C000040, 32'h20);
      expect_issue("jal", 32'h20, 32'h20, 32'd0, 32'h40, 5'd0, 5'd0, 5'd31, 5'd1,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_PASSA);
      #2 chk("jal_pcsrc", 256'(pc_src), 256'(2'd2));
      chk("jal_target", 256'(pc_target), 256'(32'h100));
      chk("jal_flush", 256'(flush_if), 256'(1'b1));
      tick();

      // immediate forms and memory ops
      drive(32'h340A8001, 32'h500);
      expect_issue("ori_zext", 32'h500, 32'd0, 32'd0, 32'h00008001, 5'd0, 5'd10, 5'd10, 5'd0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_OR);
      tick();
      drive(32'h3C0B8001, 32'h504);
      expect_issue("lui", 32'h504, 32'd0, 32'd0, 32'h80010000, 5'd0, 5'd11, 5'd11, 5'd0,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, ALU_LUI);
      tick();
      drive(32'hACA40008, 32'h508);
      expect_issue("sw", 32'h508, 32'd7, 32'h10, 32'd8, 5'd5, 5'd4, 5'd0, 5'd0,
                   1'b0, 1'b0, 1'b1, 1'b0, 1'b1, ALU_ADD);
      tick();
      drive(32'h8CACFFFC, 32'h50C);
      expect_issue("lw", 32'h50C, 32'd7, 32'd0, 32'hFFFFFFFC, 5'd5, 5'd12, 5'd12, 5'd31,
                   1'b1, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ADD);
      tick();

      // sll ignores its rs field for hazards
      drive(32'h01246880, 32'h510);
      ex_mem_read = 1'b1; ex_dest = 5'd9;
      expect_issue("sll", 32'h510, 32'd0, 32'h10, 32'h6880, 5'd9, 5'd4, 5'd13, 5'd2,
                   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_SLL);
      #2 chk("sll_nostall", 256'(stall), 256'(1'b0));
      tick();
      ex_mem_read = 1'b0; ex_dest = 5'd0;

      // unknown opcode is a bubble
      drive(32'hFC000000, 32'h514);
      #2 chk("unk_pcsrc", 256'(pc_src), 256'(2'd0));
      tick();
      chk("unk_bubble", 256'(id_ex_valid), 256'(1'b0));

      if_id_valid = 1'b0;
      repeat (3) tick();
      chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
